// File: rtl/phase_strobe_tracker_pkg.sv
// phase_strobe_tracker_pkg
//   Shared definitions for the five-phase strobe tracker: FSM state encodings,
//   error codes, the "no phase" index and a multi-hot helper.
package phase_strobe_tracker_pkg;

    localparam int unsigned NUM_PHASES = 5;

    // FSM state encodings; EXPk is numerically k so it doubles as the phase index.
    localparam logic [2:0] ST_EXP0   = 3'd0;
    localparam logic [2:0] ST_EXP1   = 3'd1;
    localparam logic [2:0] ST_EXP2   = 3'd2;
    localparam logic [2:0] ST_EXP3   = 3'd3;
    localparam logic [2:0] ST_EXP4   = 3'd4;
    localparam logic [2:0] ST_HALTED = 3'd5;
    localparam logic [2:0] ST_ERROR  = 3'd6;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_ORDER   = 2'b01;
    localparam logic [1:0] ERR_MULTI   = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

    localparam logic [2:0] PH_IDX_NONE = 3'd7;

    // True when more than one strobe bit is set.
    function automatic logic is_multi_hot(input logic [NUM_PHASES-1:0] v);
        return (v & (v - 5'd1)) != 5'd0;
    endfunction

endpackage

// File: rtl/phase_strobe_tracker_watchdog.sv
// phase_strobe_tracker_watchdog
//   Idle-clock counter between strobes of one instruction.
//   clock   in   system clock
//   reset   in   asynchronous active-high reset
//   clear   in   restart the count (accepted strobe or not inside an instruction)
//   enable  in   count this clock (idle clock inside an instruction)
//   expired out  one more idle clock reaches TIMEOUT; a strobe this clock still wins
module phase_strobe_tracker_watchdog #(
    parameter int unsigned TIMEOUT = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] count_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (enable && (count_q != LAST)) begin
            count_q <= count_q + CW'(1);
        end
    end

    assign expired = (count_q == LAST);

endmodule

// File: rtl/phase_strobe_tracker.sv
// phase_strobe_tracker
//   Receiving end of the five-phase strobe protocol. Checks strobe order,
//   drives registered per-stage enables, raises a sticky halt request,
//   counts retired instructions and flags protocol errors.
//   clock       in   system clock
//   reset       in   asynchronous active-high reset
//   phase_in    in   5  strobes, bit i = p_i
//   halt_req    in   1  decoder says current instruction is HLT
//   halt_ext    in   1  external stop request
//   stage_en    out  5  one-cycle pulse of bit i after accepted p_i
//   phase_idx   out  3  next expected phase, 7 when halted or in error
//   halt_out    out  1  sticky halt request to the controller
//   halted      out  1  FSM is HALTED
//   phase_err   out  1  sticky protocol error
//   err_code    out  2  first error cause
//   inst_count  out  COUNT_W retired instructions, wrapping
module phase_strobe_tracker
    import phase_strobe_tracker_pkg::*;
#(
    parameter int unsigned COUNT_W = 16,
    parameter int unsigned TIMEOUT = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [4:0]         phase_in,
    input  logic               halt_req,
    input  logic               halt_ext,
    output logic [4:0]         stage_en,
    output logic [2:0]         phase_idx,
    output logic               halt_out,
    output logic               halted,
    output logic               phase_err,
    output logic [1:0]         err_code,
    output logic [COUNT_W-1:0] inst_count
);

    logic [2:0]         state_q, state_d;
    logic [1:0]         err_q, err_d;
    logic               halt_q, halt_d;
    logic               perr_q;
    logic [4:0]         stage_en_q;
    logic [COUNT_W-1:0] count_q;

    logic       in_exp, counting, accept, honour, halt_pend, wd_expired;
    logic [4:0] expected;

    assign in_exp    = (state_q <= ST_EXP4);
    assign counting  = in_exp && (state_q != ST_EXP0);
    assign expected  = 5'b00001 << state_q;
    // halt_req only means something once the instruction has been decoded (after p1).
    assign honour    = (halt_ext && in_exp) ||
                       (halt_req && (state_q >= ST_EXP2) && (state_q <= ST_EXP4));
    assign halt_pend = halt_q || honour;

    phase_strobe_tracker_watchdog #(
        .TIMEOUT(TIMEOUT)
    ) u_watchdog (
        .clock  (clock),
        .reset  (reset),
        .clear  (accept || !counting),
        .enable (counting && (phase_in == 5'd0)),
        .expired(wd_expired)
    );

    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        accept  = 1'b0;
        if (in_exp) begin
            if (phase_in == 5'd0) begin
                if (counting && wd_expired) begin
                    state_d = ST_ERROR;
                    err_d   = ERR_TIMEOUT;
                end
            end else if (is_multi_hot(phase_in)) begin
                state_d = ST_ERROR;
                err_d   = ERR_MULTI;
            end else if (phase_in == expected) begin
                accept = 1'b1;
                if (state_q == ST_EXP4) begin
                    state_d = halt_pend ? ST_HALTED : ST_EXP0;
                end else begin
                    state_d = state_q + 3'd1;
                end
            end else begin
                state_d = ST_ERROR;
                err_d   = ERR_ORDER;
            end
        end else if (state_q == ST_HALTED) begin
            if (phase_in != 5'd0) begin
                state_d = ST_ERROR;
                err_d   = ERR_ORDER;
            end
        end
        // An error also stops the controller.
        halt_d = halt_pend || (state_d == ST_ERROR);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= ST_EXP0;
            err_q      <= ERR_NONE;
            halt_q     <= 1'b0;
            perr_q     <= 1'b0;
            stage_en_q <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            err_q      <= err_d;
            halt_q     <= halt_d;
            perr_q     <= perr_q || (state_d == ST_ERROR);
            stage_en_q <= accept ? phase_in : 5'd0;
            if (accept && (state_q == ST_EXP4)) begin
                count_q <= count_q + COUNT_W'(1);
            end
        end
    end

    assign stage_en   = stage_en_q;
    assign phase_idx  = in_exp ? state_q : PH_IDX_NONE;
    assign halt_out   = halt_q;
    assign halted     = (state_q == ST_HALTED);
    assign phase_err  = perr_q;
    assign err_code   = err_q;
    assign inst_count = count_q;

endmodule

// File: tb/tb_phase_strobe_tracker.sv
module tb_phase_strobe_tracker;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [4:0] phase_in = '0;
    logic       halt_req = 1'b0;
    logic       halt_ext = 1'b0;
    logic [4:0] stage_en;
    logic [2:0] phase_idx;
    logic       halt_out, halted, phase_err;
    logic [1:0] err_code;
    logic [3:0] inst_count;

    int vectors = 0;
    int miscompares = 0;

    always #5 clock = ~clock;

    phase_strobe_tracker #(
        .COUNT_W(4),
        .TIMEOUT(8)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .phase_in  (phase_in),
        .halt_req  (halt_req),
        .halt_ext  (halt_ext),
        .stage_en  (stage_en),
        .phase_idx (phase_idx),
        .halt_out  (halt_out),
        .halted    (halted),
        .phase_err (phase_err),
        .err_code  (err_code),
        .inst_count(inst_count)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic strobe(input int k);
        phase_in = 5'b00001 << k;
        tick();
        phase_in = '0;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        #2;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #1;
        vectors++;
        if ({stage_en, phase_idx, halt_out, halted, phase_err, err_code, inst_count} !== 17'd0) begin
            miscompares++;
            $display("FAIL reset_state: got en=%b idx=%0d ho=%b h=%b pe=%b ec=%b cnt=%0d want all 0",
                     stage_en, phase_idx, halt_out, halted, phase_err, err_code, inst_count);
        end
        reset = 1'b0;
    endtask

    task automatic test_clean();
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            for (int k = 0; k < 5; k++) begin
                strobe(k);
                vectors++;
                if (stage_en !== (5'b00001 << k) || phase_idx !== 3'((k + 1) % 5)) begin
                    miscompares++;
                    $display("FAIL clean_pulse: inst %0d p%0d got en=%b idx=%0d want en=%b idx=%0d",
                             i, k, stage_en, phase_idx, 5'b00001 << k, (k + 1) % 5);
                end
                tick();
                vectors++;
                if (stage_en !== 5'd0) begin
                    miscompares++;
                    $display("FAIL clean_pulse_end: got en=%b want 00000", stage_en);
                end
                tick();
            end
        end
        vectors++;
        if (inst_count !== 4'd3 || phase_err !== 1'b0 || halt_out !== 1'b0 || err_code !== 2'b00) begin
            miscompares++;
            $display("FAIL clean_final: got cnt=%0d pe=%b ho=%b ec=%b want 3 0 0 00",
                     inst_count, phase_err, halt_out, err_code);
        end
    endtask

    task automatic test_halt();
        apply_reset();
        // halt_req before decode (EXP1) is ignored
        strobe(0);
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        vectors++;
        if (halt_out !== 1'b0) begin
            miscompares++;
            $display("FAIL halt_early_ignored: got halt_out=%b want 0", halt_out);
        end
        for (int k = 1; k < 5; k++) strobe(k);
        strobe(0);
        strobe(1);
        strobe(2);
        halt_req = 1'b1;
        tick();
        vectors++;
        if (halt_out !== 1'b1 || halted !== 1'b0) begin
            miscompares++;
            $display("FAIL halt_rise: got halt_out=%b halted=%b want 1 0", halt_out, halted);
        end
        tick();
        halt_req = 1'b0;
        strobe(3);
        strobe(4);
        vectors++;
        if (halted !== 1'b1 || inst_count !== 4'd2 || phase_idx !== 3'd7 || stage_en !== 5'b10000) begin
            miscompares++;
            $display("FAIL halt_done: got h=%b cnt=%0d idx=%0d en=%b want 1 2 7 10000",
                     halted, inst_count, phase_idx, stage_en);
        end
        // halt_req coincident with p4
        apply_reset();
        for (int k = 0; k < 4; k++) strobe(k);
        phase_in = 5'b10000;
        halt_req = 1'b1;
        tick();
        phase_in = '0;
        halt_req = 1'b0;
        vectors++;
        if (halted !== 1'b1 || inst_count !== 4'd1 || halt_out !== 1'b1) begin
            miscompares++;
            $display("FAIL halt_with_p4: got h=%b cnt=%0d ho=%b want 1 1 1", halted, inst_count, halt_out);
        end
    endtask

    task automatic test_order();
        apply_reset();
        strobe(0);
        strobe(2);
        vectors++;
        if (phase_err !== 1'b1 || err_code !== 2'b01 || stage_en !== 5'd0 || halt_out !== 1'b1
            || phase_idx !== 3'd7) begin
            miscompares++;
            $display("FAIL order_err: got pe=%b ec=%b en=%b ho=%b idx=%0d want 1 01 00000 1 7",
                     phase_err, err_code, stage_en, halt_out, phase_idx);
        end
        phase_in = 5'b00011;
        tick();
        phase_in = '0;
        vectors++;
        if (err_code !== 2'b01 || stage_en !== 5'd0) begin
            miscompares++;
            $display("FAIL order_frozen: got ec=%b en=%b want 01 00000", err_code, stage_en);
        end
    endtask

    task automatic test_multi_hot();
        apply_reset();
        phase_in = 5'b00011;
        tick();
        phase_in = '0;
        vectors++;
        if (err_code !== 2'b10 || phase_err !== 1'b1 || stage_en !== 5'd0) begin
            miscompares++;
            $display("FAIL multi_hot: got ec=%b pe=%b en=%b want 10 1 00000", err_code, phase_err, stage_en);
        end
        reset = 1'b1;
        #1;
        vectors++;
        if ({stage_en, phase_idx, halt_out, halted, phase_err, err_code, inst_count} !== 17'd0) begin
            miscompares++;
            $display("FAIL multi_reset: got idx=%0d ho=%b pe=%b ec=%b want 0 0 0 00",
                     phase_idx, halt_out, phase_err, err_code);
        end
        reset = 1'b0;
        // reset mid-instruction, then restart from p0
        strobe(0);
        strobe(1);
        reset = 1'b1;
        #1;
        vectors++;
        if (phase_idx !== 3'd0 || stage_en !== 5'd0) begin
            miscompares++;
            $display("FAIL mid_reset: got idx=%0d en=%b want 0 00000", phase_idx, stage_en);
        end
        reset = 1'b0;
        strobe(0);
        vectors++;
        if (stage_en !== 5'b00001 || phase_err !== 1'b0 || phase_idx !== 3'd1) begin
            miscompares++;
            $display("FAIL restart_p0: got en=%b pe=%b idx=%0d want 00001 0 1", stage_en, phase_err, phase_idx);
        end
    endtask

    task automatic test_timeout();
        apply_reset();
        strobe(0);
        strobe(1);
        idle(7);
        vectors++;
        if (phase_err !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_early: got pe=%b want 0 after 7 idle clocks", phase_err);
        end
        idle(1);
        vectors++;
        if (err_code !== 2'b11 || phase_err !== 1'b1 || halt_out !== 1'b1) begin
            miscompares++;
            $display("FAIL timeout_err: got ec=%b pe=%b ho=%b want 11 1 1", err_code, phase_err, halt_out);
        end
        apply_reset();
        strobe(0);
        strobe(1);
        idle(7);
        strobe(2);
        vectors++;
        if (stage_en !== 5'b00100 || phase_err !== 1'b0 || phase_idx !== 3'd3) begin
            miscompares++;
            $display("FAIL timeout_strobe_wins: got en=%b pe=%b idx=%0d want 00100 0 3",
                     stage_en, phase_err, phase_idx);
        end
        idle(7);
        strobe(3);
        vectors++;
        if (stage_en !== 5'b01000 || phase_err !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_rearm: got en=%b pe=%b want 01000 0", stage_en, phase_err);
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        for (int i = 0; i < 16; i++) begin
            for (int k = 0; k < 5; k++) strobe(k);
            if (i == 14) begin
                vectors++;
                if (inst_count !== 4'd15) begin
                    miscompares++;
                    $display("FAIL wrap_pre: got cnt=%0d want 15", inst_count);
                end
            end
        end
        vectors++;
        if (inst_count !== 4'd0 || phase_err !== 1'b0) begin
            miscompares++;
            $display("FAIL wrap: got cnt=%0d pe=%b want 0 0", inst_count, phase_err);
        end
        // halt_ext in EXP0: instruction completes, then HALTED
        halt_ext = 1'b1;
        tick();
        halt_ext = 1'b0;
        vectors++;
        if (halt_out !== 1'b1 || halted !== 1'b0) begin
            miscompares++;
            $display("FAIL ext_halt_rise: got ho=%b h=%b want 1 0", halt_out, halted);
        end
        for (int k = 0; k < 5; k++) strobe(k);
        vectors++;
        if (halted !== 1'b1 || inst_count !== 4'd1) begin
            miscompares++;
            $display("FAIL ext_halted: got h=%b cnt=%0d want 1 1", halted, inst_count);
        end
        strobe(0);
        vectors++;
        if (err_code !== 2'b01 || phase_err !== 1'b1 || halted !== 1'b0 || stage_en !== 5'd0
            || phase_idx !== 3'd7) begin
            miscompares++;
            $display("FAIL strobe_in_halted: got ec=%b pe=%b h=%b en=%b idx=%0d want 01 1 0 00000 7",
                     err_code, phase_err, halted, stage_en, phase_idx);
        end
    endtask

    initial begin
        test_reset();
        test_clean();
        test_halt();
        test_order();
        test_multi_hot();
        test_timeout();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
